// File: rtl/test_status_port_if.sv
// Wishbone slave bundle for test_status_port: cycle/strobe/write request in,
// ack and read data out.
interface test_status_port_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [4:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_ack_o, wb_dat_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_ack_o, wb_dat_o
  );
endinterface

// File: rtl/test_status_port.sv
// Firmware test-progress reporter: queued PASS/FAIL results become timed pulses on
// next_test_o with a pass level on success_o. Optional watchdog: TEST_STATUS_WATCHDOG_EN.
module test_status_port #(
  parameter int unsigned PENDING_W       = 4,
  parameter logic [15:0] PULSE_DEFAULT   = 16'd32,
  parameter logic [15:0] GAP_DEFAULT     = 16'd32,
  parameter logic [23:0] WATCHDOG_CYCLES = 24'hFFFFFF
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  test_status_port_if.slave   wb,
  output logic                success_o,
  output logic                next_test_o,
  output logic [1:0]          io_oeb
);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_e;

  localparam logic [PENDING_W-1:0] PEND_MAX = '1;

  state_e                 state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [PENDING_W-1:0]   pending_q, pending_d;
  logic [15:0]            pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
  logic                   fail_seen_q, fail_seen_d;
  logic                   success_q, success_d;
  logic                   overflow_q, overflow_d;
  logic                   timeout_q, timeout_d;
  logic [15:0]            pulse_w_q, pulse_w_d, gap_q, gap_d;
  logic                   ack_q, ack_d;
  logic [31:0]            dat_q, dat_d;
  logic                   next_test_q, next_test_d;

  logic                   access, wr_en, ctrl_wr;
  logic                   wr_pass, wr_fail, wr_clear, wd_fire;
  logic                   res_pass, res_fail, enq, deq, busy;
  logic [2:0]             reg_sel;
  logic [15:0]            pass_base, fail_base, w_eff, g_eff;
  logic                   fail_seen_base, success_base;
  logic [31:0]            status;
  logic                   unused_adr;

  assign access   = wb.wb_cyc_i & wb.wb_stb_i;
  assign reg_sel  = wb.wb_adr_i[4:2];
  // Writes land on the ack cycle so they commit exactly once per access.
  assign wr_en    = access & ack_q & wb.wb_we_i;
  assign ctrl_wr  = wr_en && (reg_sel == 3'd0) && wb.wb_sel_i[0];
  assign wr_pass  = ctrl_wr & wb.wb_dat_i[0];
  assign wr_fail  = ctrl_wr & wb.wb_dat_i[1];
  assign wr_clear = ctrl_wr & wb.wb_dat_i[2];
  assign unused_adr = ^wb.wb_adr_i[1:0];

`ifdef TEST_STATUS_WATCHDOG_EN
  logic [23:0] wd_cnt_q, wd_cnt_d;
  logic        wd_arm_q, wd_arm_d;

  assign wd_fire = wd_arm_q && (wd_cnt_q == WATCHDOG_CYCLES) && !(wr_pass || wr_fail);

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    wd_arm_d = wd_arm_q;
    if (wr_pass || wr_fail) begin
      wd_arm_d = 1'b1;
      wd_cnt_d = '0;
    end else if (wd_fire) begin
      wd_arm_d = 1'b0;
      wd_cnt_d = '0;
    end else if (wd_arm_q) begin
      wd_cnt_d = wd_cnt_q + 24'd1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wd_cnt_q <= '0;
      wd_arm_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_arm_q <= wd_arm_d;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  assign res_fail = wr_fail | wd_fire;
  assign res_pass = wr_pass & ~res_fail;
  assign enq      = res_pass | res_fail;
  assign busy     = (state_q != S_IDLE) || (pending_q != '0);
  assign w_eff    = (pulse_w_q == 16'd0) ? 16'd1 : pulse_w_q;
  assign g_eff    = (gap_q == 16'd0) ? 16'd1 : gap_q;
  assign status   = {16'd0, 8'(pending_q), 4'd0, timeout_q, overflow_q, busy, success_q};

  // Result bookkeeping: CLEAR is applied before a result in the same write.
  always_comb begin
    pass_base      = wr_clear ? 16'd0 : pass_cnt_q;
    fail_base      = wr_clear ? 16'd0 : fail_cnt_q;
    fail_seen_base = wr_clear ? 1'b0  : fail_seen_q;
    success_base   = wr_clear ? 1'b0  : success_q;
    pass_cnt_d     = pass_base;
    fail_cnt_d     = fail_base;
    if (res_pass && pass_base != 16'hFFFF) pass_cnt_d = pass_base + 16'd1;
    if (res_fail && fail_base != 16'hFFFF) fail_cnt_d = fail_base + 16'd1;
    fail_seen_d = fail_seen_base | res_fail;
    if (res_fail)      success_d = 1'b0;
    else if (res_pass) success_d = ~fail_seen_base;
    else               success_d = success_base;
    timeout_d = (wr_clear ? 1'b0 : timeout_q) | wd_fire;
  end

  always_comb begin
    pulse_w_d = pulse_w_q;
    gap_d     = gap_q;
    if (wr_en && reg_sel == 3'd3) begin
      if (wb.wb_sel_i[0]) pulse_w_d[7:0]  = wb.wb_dat_i[7:0];
      if (wb.wb_sel_i[1]) pulse_w_d[15:8] = wb.wb_dat_i[15:8];
      if (wb.wb_sel_i[2]) gap_d[7:0]      = wb.wb_dat_i[23:16];
      if (wb.wb_sel_i[3]) gap_d[15:8]     = wb.wb_dat_i[31:24];
    end
  end

  // Pulse FSM: phase lengths are latched on entry, so TIMING writes never stretch a live phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    deq     = 1'b0;
    case (state_q)
      S_IDLE: if (pending_q != '0) begin
        state_d = S_HIGH;
        cnt_d   = w_eff;
        deq     = 1'b1;
      end
      S_HIGH: if (cnt_q <= 16'd1) begin
        state_d = S_LOW;
        cnt_d   = g_eff;
      end else cnt_d = cnt_q - 16'd1;
      S_LOW: if (cnt_q <= 16'd1) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else cnt_d = cnt_q - 16'd1;
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    next_test_d = (state_d == S_HIGH);
  end

  always_comb begin
    pending_d  = pending_q;
    overflow_d = wr_clear ? 1'b0 : overflow_q;
    if (enq && !deq) begin
      if (pending_q == PEND_MAX) overflow_d = 1'b1;
      else                       pending_d  = pending_q + 1'b1;
    end else if (deq && !enq) begin
      pending_d = pending_q - 1'b1;
    end
  end

  always_comb begin
    ack_d = access & ~ack_q;
    dat_d = '0;
    if (ack_d && !wb.wb_we_i) begin
      case (reg_sel)
        3'd1:    dat_d = status;
        3'd2:    dat_d = {fail_cnt_q, pass_cnt_q};
        3'd3:    dat_d = {gap_q, pulse_w_q};
        default: dat_d = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pending_q   <= '0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      fail_seen_q <= 1'b0;
      success_q   <= 1'b0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
      pulse_w_q   <= PULSE_DEFAULT;
      gap_q       <= GAP_DEFAULT;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      next_test_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      fail_seen_q <= fail_seen_d;
      success_q   <= success_d;
      overflow_q  <= overflow_d;
      timeout_q   <= timeout_d;
      pulse_w_q   <= pulse_w_d;
      gap_q       <= gap_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      next_test_q <= next_test_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign success_o   = success_q;
  assign next_test_o = next_test_q;
  assign io_oeb      = 2'b00;

endmodule
